wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between two requesters:
  - the pipeline W stage, with three writeback sources: ALU result, memory data, PC+8;
  - a multi-cycle multiply/divide unit (MDU) whose GPR results arrive out of band.
- Queues MDU results in a small buffer and retires them into idle W-stage slots.
- Forces a pipeline bubble when a queued result has waited too long.
- Sits between the W-stage pipeline register and the GRF write inputs.

Parameters:
- DEPTH, 4, MDU result buffer entries (power of two, 2..16).
- MAX_WAIT, 8, cycles the head entry may wait before stall_req asserts (1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- w_valid  in  1  W stage holds a live instruction that writes a GPR
- w_a3  in  5  W-stage destination register
- w_sel  in  2  writeback source select: 00 ALU, 01 Mem, 10 PC8, 11 reserved (treated as ALU)
- w_alu  in  32  ALU result
- w_mem  in  32  memory load data
- w_pc8  in  32  PC+8 link value
- md_valid  in  1  MDU presents a result
- md_a3  in  5  MDU destination register
- md_data  in  32  MDU result data
- md_ready  out  1  buffer can accept; combinational, equals (count < DEPTH)
- rf_we  out  1  GRF write enable, registered
- rf_a3  out  5  GRF write address, registered
- rf_wd  out  32  GRF write data, registered
- stall_req  out  1  registered request that the pipeline insert a bubble in W
- pending  out  1  buffer non-empty (count != 0)

Behaviour:
- Reset (reset=0, async): rf_we=0, rf_a3=0, rf_wd=0, stall_req=0, buffer empty, count=0, age=0, state IDLE.
- Latency: a write selected in cycle N appears on rf_* after the rising edge ending cycle N, i.e. one cycle.
- W slot is live when w_valid=1 and w_a3!=0.
- W stage always wins the port. A live W slot drives:
  - rf_we=1, rf_a3=w_a3;
  - rf_wd = mux(w_sel) over w_alu / w_mem / w_pc8.
- If the W slot is not live and the buffer head is valid, the head is popped into rf_* with rf_we=1.
- If the W slot is not live and the head is killed, the head is popped with rf_we=0; the slot is consumed.
- Otherwise rf_we=0; rf_a3 and rf_wd hold their previous values.
- Writes to $0 never occur:
  - W with w_a3=0 is not live;
  - MDU transfers with md_a3=0 are accepted but not enqueued.
- Enqueue occurs when md_valid && md_ready. Enqueue and pop in the same cycle are allowed; count is unchanged when both happen.
- Ordering/kill rule:
  - A live W write to register R clears the valid bit of every buffered entry with a3==R, since those are older results.
  - An MDU result arriving in the same cycle with md_a3==R is also dropped: it is accepted but not enqueued.
- Full buffer: md_ready=0; the MDU must hold md_valid/md_a3/md_data stable until accepted.
- age counts consecutive cycles in which the buffer is non-empty and the head is not popped. It clears on any pop and when the buffer becomes empty.
- FSM:
  - IDLE (empty) -> DRAIN on first enqueue.
  - DRAIN -> IDLE when the last entry pops with no simultaneous enqueue.
  - DRAIN -> FORCE when age reaches MAX_WAIT-1 and no pop occurs that cycle.
  - FORCE: stall_req=1.
  - FORCE -> DRAIN on the head pop, or -> IDLE if that pop empties the buffer. stall_req drops in the same edge.
- While stall_req=1 the pipeline must present w_valid=0. If W is live anyway, W still wins and FORCE persists.
- Buffer pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Test Plan:
- Reset mid-traffic: 3 entries buffered and stall_req=1, drive reset=0 between edges -> rf_we=0, stall_req=0, pending=0 and md_ready=1 immediately, without waiting for a clock edge.
- Source select: w_valid=1, w_a3=5, w_alu=0x11, w_mem=0x22, w_pc8=0x3008, w_sel swept 00/01/10/11 -> rf_wd 0x11/0x22/0x3008/0x11 one cycle later, rf_a3=5, rf_we=1.
- Drain into idle slot: enqueue md_a3=9, md_data=0xDEAD while w_valid=1 (w_a3=3), next cycle w_valid=0 -> edge 1 writes reg 3, edge 2 writes reg 9 = 0xDEAD, pending=0 afterwards.
- Kill ordering:
  - buffer holds {a3=7, 0xAAAA}, then a live W write to 7 with 0xBBBB, then an idle slot;
  - required: reg 7 written 0xBBBB only, the killed head pops with rf_we=0, no 0xAAAA write ever.
  - Same-cycle case: md_a3=7 arrives with the W write to 7 -> not enqueued.
- Full/backpressure: DEPTH=4, w_valid=1 (w_a3!=0) continuously, 5 MDU results offered -> md_ready=0 after the 4th accept, the 5th is held, and the 5th is accepted the cycle after the first pop.
- Starvation: 1 entry buffered, w_valid=1 (w_a3!=0) every cycle, MAX_WAIT=8 -> stall_req rises 8 cycles after enqueue. Pipeline then drops w_valid -> the entry writes and stall_req falls on the same edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Owns the single GPR write port. Two requesters share it:
//   - the W pipeline stage (ALU / Mem / PC+8 writeback);
//   - the multiply/divide unit, whose results are queued in a small FIFO.
// W always wins. Queued results retire into idle W slots. A result that
// has waited too long raises stall_req so the pipeline inserts a bubble.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   w_valid, w_a3, w_sel W-stage write request, destination, source select
//   w_alu, w_mem, w_pc8  candidate writeback values
//   md_valid, md_a3,     MDU result offer
//   md_data
//   md_ready             MDU handshake ready (combinational)
//   rf_we, rf_a3, rf_wd  registered GRF write port
//   stall_req            registered bubble request
//   pending              buffer holds at least one entry
//
// Handshake: an MDU transfer happens on a rising edge where md_valid and
// md_ready are both 1. md_ready depends only on the buffer occupancy, never
// on md_valid. While md_valid=1 and md_ready=0 the MDU keeps md_a3/md_data
// stable. A transfer to $0, or one that collides with a live W write to the
// same register, is accepted but dropped.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_valid,
  input  logic [4:0]  w_a3,
  input  logic [1:0]  w_sel,
  input  logic [31:0] w_alu,
  input  logic [31:0] w_mem,
  input  logic [31:0] w_pc8,
  input  logic        md_valid,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        stall_req,
  output logic        pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    AGE_LIM = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    age_q, age_d;
  logic [DEPTH-1:0] ent_v_q, ent_v_d;
  logic [4:0]    ent_a3_q [DEPTH];
  logic [4:0]    ent_a3_d [DEPTH];
  logic [31:0]   ent_wd_q [DEPTH];
  logic [31:0]   ent_wd_d [DEPTH];
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_a3_q, rf_a3_d;
  logic [31:0]   rf_wd_q, rf_wd_d;

  logic          w_live;
  logic          pop;
  logic          enq;
  logic [31:0]   w_data;

  assign md_ready  = (count_q < DEPTH_C);
  assign pending   = (count_q != '0);
  assign w_live    = w_valid && (w_a3 != 5'd0);
  // Any idle W slot consumes the head, even a killed one.
  assign pop       = !w_live && pending;
  assign enq       = md_valid && md_ready && (md_a3 != 5'd0) &&
                     !(w_live && (md_a3 == w_a3));

  assign rf_we     = rf_we_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;
  assign stall_req = (state_q == S_FORCE);

  always_comb begin
    case (w_sel)
      2'b01:   w_data = w_mem;
      2'b10:   w_data = w_pc8;
      default: w_data = w_alu;
    endcase
  end

  always_comb begin
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd_d  = rf_wd_q;
    ent_v_d  = ent_v_q;
    ent_a3_d = ent_a3_q;
    ent_wd_d = ent_wd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (w_live) begin
      rf_we_d = 1'b1;
      rf_a3_d = w_a3;
      rf_wd_d = w_data;
      // Buffered results for the same register are older than this write.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_a3_q[i] == w_a3) ent_v_d[i] = 1'b0;
      end
    end else if (pop) begin
      if (ent_v_q[rd_ptr_q]) begin
        rf_we_d = 1'b1;
        rf_a3_d = ent_a3_q[rd_ptr_q];
        rf_wd_d = ent_wd_q[rd_ptr_q];
      end
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // The slot at wr_ptr is free whenever enq can be 1, so the kill loop
    // above never touches the entry written here.
    if (enq) begin
      ent_v_d[wr_ptr_q]  = 1'b1;
      ent_a3_d[wr_ptr_q] = md_a3;
      ent_wd_d[wr_ptr_q] = md_data;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(enq) - CW'(pop);

    if (pending && !pop) begin
      age_d = (age_q == 8'hFF) ? age_q : age_q + 8'd1;
    end else begin
      age_d = 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enq) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
        end else if (!pop && (age_q >= AGE_LIM)) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        if (pop) state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      ent_v_q  <= '0;
      ent_a3_q <= '{default: '0};
      ent_wd_q <= '{default: '0};
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      ent_v_q  <= ent_v_d;
      ent_a3_q <= ent_a3_d;
      ent_wd_q <= ent_wd_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

endmodule
